// File: rtl/qos_egress.sv
// qos_egress: pops the QoS output FIFO into a 2-entry skid buffer, drives a valid/ready link, frames words and reports idle.
module qos_egress #(
    parameter int DATA_WIDTH  = 4,
    parameter int FRAME_LEN   = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int IDLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_out,
    output logic                  rd_en,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  word_count
);
    localparam int BW = $clog2(FRAME_LEN);
    localparam int GW = $clog2(IDLE_CYCLES + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_GAP} state_t;
    state_t state, state_n;
    logic [1:0] occ, occ_p;
    logic inflight, xfer, has_data;
    logic [BW-1:0] beat;
    logic [GW-1:0] gap, gap_n;
    logic [DATA_WIDTH-1:0] head, tail;
    assign out_valid = (occ != 2'd0) & enb;
    assign xfer      = out_valid & out_ready;
    // Words already in flight from the FIFO reserve a slot, so occ never exceeds 2.
    assign rd_en     = rst & enb & ~buf_empty & ((occ + {1'b0, inflight} - {1'b0, xfer}) < 2'd2);
    assign occ_p     = occ - {1'b0, xfer};
    assign out_data  = head;
    assign out_sof   = out_valid & (beat == '0);
    assign out_eof   = out_valid & (beat == BW'(FRAME_LEN - 1));
    assign idle      = (state == S_IDLE);
    assign has_data  = (occ != 2'd0) | inflight;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head       <= '0;
            tail       <= '0;
            beat       <= '0;
            word_count <= '0;
            state      <= S_IDLE;
            gap        <= '0;
        end else begin
            inflight <= rd_en;
            occ      <= occ_p + {1'b0, inflight};
            if (xfer) head <= tail;
            if (inflight && occ_p == 2'd0) head <= buf_out;
            if (inflight && occ_p != 2'd0) tail <= buf_out;
            if (xfer) beat <= (beat == BW'(FRAME_LEN - 1)) ? '0 : beat + 1'b1;
            if (xfer && word_count != '1) word_count <= word_count + 1'b1;
            state <= state_n;
            gap   <= gap_n;
        end
    end
    always_comb begin
        state_n = state;
        gap_n   = gap;
        case (state)
            S_IDLE: state_n = has_data ? S_RUN : S_IDLE;
            S_RUN: begin
                gap_n = '0;
                if (!has_data) state_n = (beat != '0) ? S_WAIT : S_GAP;
            end
            S_WAIT: state_n = has_data ? S_RUN : S_WAIT;
            S_GAP: begin
                if (has_data) begin
                    state_n = S_RUN;
                    gap_n   = '0;
                end else if (buf_empty) begin
                    state_n = (gap == GW'(IDLE_CYCLES - 1)) ? S_IDLE : S_GAP;
                    gap_n   = (gap == GW'(IDLE_CYCLES - 1)) ? '0 : gap + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_qos_egress.sv
// tb_qos_egress: directed checks of qos_egress against a FIFO model and an in-order scoreboard.
module tb_qos_egress;
    logic clk = 1'b0, rst = 1'b0, enb = 1'b1, out_ready = 1'b1;
    logic buf_empty, rd_en, out_valid, out_sof, out_eof, idle;
    logic [3:0] buf_out = '0, out_data;
    logic [15:0] word_count;
    logic s_enb = 1'b1, s_empty = 1'b1, s_ready = 1'b1;
    logic [3:0] s_out = 4'h0, s_data;
    logic s_rd_en, s_valid, s_sof, s_eof, s_idle;
    logic [2:0] s_wc;
    logic [3:0] mem [64];
    int wp = 0, rp = 0, dp = 0, tb_beat = 0, total = 0, passes = 0;

    always #5 clk = ~clk;

    qos_egress u_dut (
        .clk(clk), .rst(rst), .enb(enb), .buf_empty(buf_empty), .buf_out(buf_out),
        .rd_en(rd_en), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof), .idle(idle), .word_count(word_count)
    );

    qos_egress #(.CNT_WIDTH(3)) u_sat (
        .clk(clk), .rst(rst), .enb(s_enb), .buf_empty(s_empty), .buf_out(s_out),
        .rd_en(s_rd_en), .out_ready(s_ready), .out_valid(s_valid), .out_data(s_data),
        .out_sof(s_sof), .out_eof(s_eof), .idle(s_idle), .word_count(s_wc)
    );

    // FIFO model: read data appears one cycle after rd_en.
    assign buf_empty = (rp == wp);
    always @(posedge clk) begin
        if (rd_en) begin
            buf_out <= mem[rp[5:0]];
            rp <= rp + 1;
        end
    end

    task automatic push(input logic [3:0] v);
        mem[wp[5:0]] = v;
        wp++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sample just after the falling edge; a handshake seen here completes at the next rising edge.
    task automatic tick();
        #1;
        if (out_valid && out_ready) begin
            if (dp == wp) chk("extra_word", out_valid, 0);
            else begin
                chk("data", out_data, mem[dp[5:0]]);
                chk("sof", out_sof, tb_beat == 0);
                chk("eof", out_eof, tb_beat == 3);
                dp++;
                tb_beat = (tb_beat + 1) % 4;
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            adv();
        end
    endtask

    task automatic drain(input int max);
        int i;
        i = 0;
        while (dp != wp && i < max) begin
            tick();
            adv();
            i++;
        end
        chk("drain", dp, wp);
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        tick();
        while (!idle && i < max) begin
            adv();
            tick();
            i++;
        end
        chk("idle", idle, 1);
        adv();
    endtask

    initial begin
        int cnt, n;
        // reset with a full FIFO
        for (int i = 1; i <= 8; i++) push(4'(i));
        adv();
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_wc", word_count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sof", out_sof, 0);
        adv();
        rst = 1'b1;
        tick();
        chk("rel_rd_en", rd_en, 1);
        chk("rel_valid", out_valid, 0);
        adv();
        tick();
        chk("lat_valid", out_valid, 0);
        adv();
        // streaming: one word per cycle
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("stream_valid", out_valid, 1);
            adv();
        end
        tick();
        chk("stream_wc", word_count, 8);
        chk("stream_idle0", idle, 0);
        chk("stream_valid0", out_valid, 0);
        adv();
        wait_idle(10);
        // backpressure
        for (int i = 1; i <= 8; i++) push(4'(i + 8));
        watch(4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", out_data, mem[dp[5:0]]);
            if (i > 0) chk("bp_rd_en", rd_en, 0);
            adv();
        end
        out_ready = 1'b1;
        drain(30);
        tick();
        chk("bp_wc", word_count, 16);
        adv();
        // open frame: two words, then a long dry spell
        push(4'h3);
        push(4'h5);
        drain(20);
        watch(10);
        tick();
        chk("open_idle", idle, 0);
        chk("open_valid", out_valid, 0);
        adv();
        push(4'h6);
        push(4'hc);
        drain(20);
        tick();
        chk("open_wc", word_count, 20);
        adv();
        wait_idle(10);
        // enable toggle mid-stream
        for (int i = 1; i <= 8; i++) push(4'(16 - i));
        watch(4);
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("enb_valid", out_valid, 0);
            chk("enb_rd_en", rd_en, 0);
            chk("enb_wc", word_count, dp);
            adv();
        end
        enb = 1'b1;
        drain(30);
        tick();
        chk("enb_wc_end", word_count, 28);
        adv();
        // counter saturation on a 3-bit instance
        s_empty = 1'b0;
        cnt = 0;
        n = 0;
        while (cnt < 10 && n < 60) begin
            @(negedge clk);
            #1;
            if (s_valid && s_ready) cnt++;
            n++;
        end
        s_empty = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("sat_xfers", cnt, 10);
        chk("sat_wc", s_wc, 7);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
